// File: rtl/pot_a2d_intf_pkg.sv
// Shared types and timing constants for the potentiometer ADC interface.
// The SPI master and the conversion sequencer both import this package.
package pot_a2d_intf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FRAME1,
    GAP,
    FRAME2,
    DONE
  } state_e;

  localparam int unsigned SCLK_HALF  = 16;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned PORCH      = 16;
  localparam int unsigned GAP_CLKS   = 32;

  localparam int unsigned BIT_CLKS   = 2 * SCLK_HALF;
  localparam int unsigned FRAME_CLKS = 2 * PORCH + FRAME_BITS * BIT_CLKS;
  localparam int unsigned BITS_END   = PORCH + FRAME_BITS * BIT_CLKS;
  localparam int unsigned FCNT_W     = 10;
  localparam int unsigned GCNT_W     = 5;
  localparam int unsigned CELL_W     = $clog2(BIT_CLKS);

  // Command word: two zero bits, channel address, then don't-care zeros.
  function automatic logic [15:0] adc_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'b0};
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// One 16-bit SPI frame: chip select, SCLK, MOSI and MISO shifting.
// A frame takes FRAME_CLKS clocks; o_done_c flags its final cycle.
module spi_mstr16
  import pot_a2d_intf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_cmd,
  input  logic        i_miso,
  output logic        o_ss_n,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_done_c,
  output logic [15:0] o_shift
);

  logic              r_active;
  logic [FCNT_W-1:0] r_cnt;
  logic [15:0]       r_shift;
  logic [FCNT_W-1:0] w_cnt_nxt;
  logic [FCNT_W-1:0] w_off;
  logic [CELL_W-1:0] w_cell_off;
  logic [3:0]        w_bit;
  logic              w_in_bits;
  logic              w_last;

  // Outputs are computed from the count they will display next cycle.
  assign w_cnt_nxt  = r_cnt + FCNT_W'(1);
  assign w_last     = r_active && (r_cnt == FCNT_W'(FRAME_CLKS - 1));
  assign w_in_bits  = (w_cnt_nxt >= FCNT_W'(PORCH)) && (w_cnt_nxt < FCNT_W'(BITS_END));
  assign w_off      = w_cnt_nxt - FCNT_W'(PORCH);
  assign w_cell_off = w_off[CELL_W-1:0];
  assign w_bit      = 4'(w_off >> CELL_W);
  assign o_done_c   = w_last;
  assign o_shift    = r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      o_ss_n   <= 1'b1;
      o_sclk   <= 1'b1;
      o_mosi   <= 1'b0;
    end else if (i_start && !r_active) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      o_ss_n   <= 1'b0;
      o_sclk   <= 1'b1;
      o_mosi   <= 1'b0;
    end else if (w_last) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      o_ss_n   <= 1'b1;
      o_sclk   <= 1'b1;
      o_mosi   <= 1'b0;
    end else if (r_active) begin
      r_cnt  <= w_cnt_nxt;
      o_sclk <= !w_in_bits || (w_cell_off >= CELL_W'(SCLK_HALF));
      // MOSI moves with the falling SCLK; MISO is captured on the rising one.
      if (w_in_bits && (w_cell_off == CELL_W'(0))) begin
        o_mosi <= i_cmd[4'd15 - w_bit];
      end
      if (w_in_bits && (w_cell_off == CELL_W'(SCLK_HALF))) begin
        r_shift <= {r_shift[14:0], i_miso};
      end
    end
  end

endmodule

// File: rtl/pot_a2d_intf.sv
// Periodic potentiometer sampler: two back-to-back ADC frames per conversion,
// the second frame's 12-bit result is published on pot with a pot_vld strobe.
module pot_a2d_intf
  import pot_a2d_intf_pkg::*;
#(
  parameter logic [2:0]  CHANNEL = 3'd0,
  parameter int unsigned PERIOD  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] pot,
  output logic        pot_vld,
  output logic        busy
);

  localparam int unsigned PCNT_W = 16;

  state_e            r_state;
  logic [PCNT_W-1:0] r_per_cnt;
  logic [GCNT_W-1:0] r_gap_cnt;
  logic              w_wrap;
  logic              w_start;
  logic              w_gap_end;
  logic              w_spi_start;
  logic              w_frame_done;
  logic [15:0]       w_shift;

  assign w_wrap      = (r_per_cnt == PCNT_W'(PERIOD - 1));
  assign w_start     = w_wrap && en && (r_state == IDLE);
  assign w_gap_end   = (r_state == GAP) && (r_gap_cnt == GCNT_W'(GAP_CLKS - 1));
  assign w_spi_start = w_start || w_gap_end;

  spi_mstr16 u_spi (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_spi_start),
    .i_cmd    (adc_cmd(CHANNEL)),
    .i_miso   (MISO),
    .o_ss_n   (SS_n),
    .o_sclk   (SCLK),
    .o_mosi   (MOSI),
    .o_done_c (w_frame_done),
    .o_shift  (w_shift)
  );

  // Free-running period counter; wraps whether or not a conversion is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
    end else if (w_wrap) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + PCNT_W'(1);
    end
  end

  // Conversion sequencer; FRAME1 only primes the ADC, its data is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
      pot       <= 12'h000;
      pot_vld   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pot_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= FRAME1;
            busy    <= 1'b1;
          end
        end
        FRAME1: begin
          if (w_frame_done) begin
            r_state   <= GAP;
            r_gap_cnt <= '0;
          end
        end
        GAP: begin
          if (w_gap_end) begin
            r_state <= FRAME2;
          end else begin
            r_gap_cnt <= r_gap_cnt + GCNT_W'(1);
          end
        end
        FRAME2: begin
          if (w_frame_done) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          pot     <= 12'(w_shift);
          pot_vld <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pot_a2d_intf.md
POT_A2D_INTF -- requirements
Module: pot_a2d_intf

Interface
REQ-001 Parameter CHANNEL, default 3'd0: ADC channel address sent in every frame.
REQ-002 Parameter PERIOD, default 4096: clocks between conversion starts; legal range 1200..65535.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 en  input  1  enables periodic conversions when high.
REQ-006 MISO  input  1  serial data from the ADC.
REQ-007 SS_n  output  1  ADC chip select, active-low.
REQ-008 SCLK  output  1  SPI clock, idles high.
REQ-009 MOSI  output  1  serial command to the ADC.
REQ-010 pot  output  12  latest unsigned potentiometer reading; feeds the volume scaler's pot input.
REQ-011 pot_vld  output  1  one-clock pulse in the cycle pot updates.
REQ-012 busy  output  1  high from conversion start through DONE inclusive.

Function
REQ-013 The block SHALL run a free-running period counter from 0 to PERIOD-1 that wraps to 0; a conversion SHALL start on wrap only when en=1 and the state is IDLE.
REQ-014 The FSM SHALL use states IDLE, FRAME1, GAP, FRAME2, DONE: IDLE->FRAME1 on start; FRAME1->GAP at frame end; GAP->FRAME2 after 32 clocks; FRAME2->DONE at frame end; DONE->IDLE after one clock.
REQ-015 Each frame SHALL take exactly 544 clocks: SS_n low throughout; 16-clock front porch with SCLK high; 16 bit cells of 32 clocks each (SCLK low for 16, high for 16); 16-clock back porch with SCLK high.
REQ-016 MOSI SHALL carry {2'b00, CHANNEL, 11'b0} MSB first, changing only on the clock SCLK goes low; it SHALL be 0 outside frames.
REQ-017 MISO SHALL be sampled into a 16-bit shift register on the clock SCLK goes high, MSB first.
REQ-018 SS_n SHALL be high in IDLE, GAP and DONE.
REQ-019 FRAME1 data SHALL be discarded because it holds the previous address's result; in DONE, pot SHALL load shift[11:0] from FRAME2 and pot_vld SHALL pulse.
REQ-020 Conversion latency from start to pot_vld SHALL be 544+32+544+1 = 1121 clocks.
REQ-021 Deasserting en mid-conversion SHALL NOT abort it; that conversion completes and no new one starts.
REQ-022 A period wrap outside IDLE SHALL be ignored; no start is queued.
REQ-023 pot SHALL hold its value between updates; shift[15:12] SHALL be ignored.

Reset
REQ-024 On rst_n low, immediately: state IDLE, SS_n=1, SCLK=1, MOSI=0, pot=12'h000, pot_vld=0, busy=0, period counter=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with SS_n high in the same cycle; pot SHALL NOT update from the aborted conversion.
REQ-026 After rst_n rises, the first possible start SHALL be at the first period wrap (PERIOD clocks later).

Structure
REQ-027 A shared package SHALL hold the state enum, SCLK_HALF=16, FRAME_BITS=16, PORCH=16 and GAP_CLKS=32.
REQ-028 A single sub-module spi_mstr16 SHALL generate SS_n, SCLK and MOSI and perform MISO shifting for one 16-bit frame, with start and done strobes; pot_a2d_intf SHALL hold the period counter, FSM and pot register.

Verification
REQ-029 The ADC model SHALL return 12'hA5C on every frame with en=1 and CHANNEL=3 -> MOSI bits 13:11 = 3'b011 in both frames, pot=12'hA5C, pot_vld is one clock, and it occurs 1121 clocks after SS_n first falls.
REQ-030 The model SHALL return 12'h123 in FRAME1 and 12'hFFF in FRAME2 -> pot=12'hFFF.
REQ-031 With a single conversion running, each frame SHALL show SS_n low for exactly 544 clocks, SCLK with 16 low pulses of 16 clocks each, and SS_n high for 32 clocks between the frames.
REQ-032 Deasserting en at clock 300 of FRAME1 -> that conversion completes with a pot_vld pulse; no further SS_n activity for 3 × PERIOD.
REQ-033 Asserting rst_n low at clock 700 of a conversion -> SS_n=1, SCLK=1 and pot=0 within the same cycle; no pot_vld until a fresh conversion completes.
REQ-034 With PERIOD=1200 and en=1 held -> starts spaced exactly 1200 clocks apart, and no start is lost or doubled over 10 periods.
